// File: rtl/shiftreg_rx_deser_if.sv
// Handshake/data bundle between the upstream PISO shift register, the
// serial-to-parallel receiver and the byte consumer.
interface shiftreg_rx_deser_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH);

  logic             sin;
  logic             carga;
  logic             shift;
  logic             dato_ack;
  logic [WIDTH-1:0] dato_out;
  logic             dato_valid;
  logic             overrun;
  logic             busy;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output sin, carga, shift, dato_ack,
    input  dato_out, dato_valid, overrun, busy, bit_cnt
  );

  modport slave (
    input  sin, carga, shift, dato_ack,
    output dato_out, dato_valid, overrun, busy, bit_cnt
  );
endinterface

// File: rtl/shiftreg_rx_deser.sv
// Serial-to-parallel receiver: rebuilds MSB-first frames sampled on the
// upstream shift strobe and offers them through a valid/ack holding register.
module shiftreg_rx_deser #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  shiftreg_rx_deser_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Only WIDTH-1 bits are ever needed: the last bit comes straight from sin.
  logic [WIDTH-2:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] dato_out_q, dato_out_d;
  logic             dato_valid_q, dato_valid_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;
  logic             complete_s;
  logic [WIDTH-1:0] frame_s;

  assign frame_s = {sreg_q, bus.sin};

  // Frame assembly: carga restarts, shift samples sin and advances the FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sreg_d     = sreg_q;
    complete_s = 1'b0;
    if (bus.carga) begin
      state_d = ST_IDLE;
      cnt_d   = {CNT_W{1'b0}};
      sreg_d  = {(WIDTH-1){1'b0}};
    end else if (bus.shift) begin
      sreg_d = {sreg_q[WIDTH-3:0], bus.sin};
      case (state_q)
        ST_IDLE: begin
          state_d = ST_RECV;
          cnt_d   = CNT_W'(1);
        end
        ST_RECV: begin
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            state_d    = ST_IDLE;
            cnt_d      = {CNT_W{1'b0}};
            complete_s = 1'b1;
          end else begin
            state_d = ST_RECV;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
    busy_d = (state_d == ST_RECV);
  end

  // Holding register: a completed frame replaces the byte only if it is free or acked now.
  always_comb begin
    dato_out_d   = dato_out_q;
    dato_valid_d = dato_valid_q;
    overrun_d    = overrun_q;
    if (complete_s) begin
      if (!dato_valid_q || bus.dato_ack) begin
        dato_out_d   = frame_s;
        dato_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (dato_valid_q && bus.dato_ack) begin
      dato_valid_d = 1'b0;
    end else begin
      dato_valid_d = dato_valid_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      sreg_q       <= {(WIDTH-1){1'b0}};
      dato_out_q   <= {WIDTH{1'b0}};
      dato_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sreg_q       <= sreg_d;
      dato_out_q   <= dato_out_d;
      dato_valid_q <= dato_valid_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.dato_out   = dato_out_q;
  assign bus.dato_valid = dato_valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = busy_q;
  assign bus.bit_cnt    = cnt_q;
endmodule

// File: tb/tb_shiftreg_rx_deser.sv
// Directed bench for shiftreg_rx_deser: a per-cycle vector table for the
// basic frame and overrun cases, then hand-written multi-cycle sequences.
module tb_shiftreg_rx_deser;
  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  shiftreg_rx_deser_if #(.WIDTH(8)) bus ();

  shiftreg_rx_deser #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       carga;
    logic       shift;
    logic       sin;
    logic       ack;
    logic [7:0] exp_out;
    logic       exp_valid;
    logic       exp_ovr;
    logic       exp_busy;
    logic [2:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_out, input logic e_valid,
                         input logic e_ovr, input logic e_busy, input logic [2:0] e_cnt);
    chk({tag, ".dato_out"},   32'(bus.dato_out),   32'(e_out));
    chk({tag, ".dato_valid"}, 32'(bus.dato_valid), 32'(e_valid));
    chk({tag, ".overrun"},    32'(bus.overrun),    32'(e_ovr));
    chk({tag, ".busy"},       32'(bus.busy),       32'(e_busy));
    chk({tag, ".bit_cnt"},    32'(bus.bit_cnt),    32'(e_cnt));
  endtask

  task automatic step(input logic c, input logic s, input logic d, input logic a);
    bus.carga    = c;
    bus.shift    = s;
    bus.sin      = d;
    bus.dato_ack = a;
    @(posedge clk);
    #1;
    bus.carga    = 1'b0;
    bus.shift    = 1'b0;
    bus.sin      = 1'b0;
    bus.dato_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(1'b0, 1'b1, 1'b1, 1'b1);
    reset_n = 1'b1;
  endtask

  // Shift n bits of an upstream byte, MSB first; optional ack on the last bit.
  task automatic shift_bits(input logic [7:0] data, input int n, input logic ack_last);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, data[7-i], (i == n-1) ? ack_last : 1'b0);
    end
  endtask

  function automatic vec_t mk(input logic c, input logic s, input logic d, input logic a,
                              input logic [7:0] eo, input logic ev, input logic eov,
                              input logic eb, input logic [2:0] ec);
    vec_t v;
    v.carga = c; v.shift = s; v.sin = d; v.ack = a;
    v.exp_out = eo; v.exp_valid = ev; v.exp_ovr = eov; v.exp_busy = eb; v.exp_cnt = ec;
    return v;
  endfunction

  initial begin
    logic [7:0] b_aa;
    logic [7:0] b_55;
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b1;
    bus.carga = 1'b0; bus.shift = 1'b0; bus.sin = 1'b0; bus.dato_ack = 1'b0;
    b_aa = 8'hAA;
    b_55 = 8'h55;

    // T1: load 0xAA, 8 shifts -> byte valid, FSM back to idle.
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0));
    for (int i = 0; i < 8; i++) begin
      vecs.push_back(mk(1'b0, 1'b1, b_aa[7-i], 1'b0,
                        (i == 7) ? 8'hAA : 8'h00, (i == 7), 1'b0, (i < 7), 3'((i + 1) % 8)));
    end
    // T3: another frame of 0x55 with 0xAA still unread -> dropped, overrun.
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'hAA, 1'b1, 1'b0, 1'b0, 3'd0));
    for (int i = 0; i < 8; i++) begin
      vecs.push_back(mk(1'b0, 1'b1, b_55[7-i], 1'b0,
                        8'hAA, 1'b1, (i == 7), (i < 7), 3'((i + 1) % 8)));
    end
    // Ack clears valid, keeps data; overrun stays sticky; second ack ignored.
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 3'd0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 3'd0));

    do_reset();
    chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);

    foreach (vecs[k]) begin
      step(vecs[k].carga, vecs[k].shift, vecs[k].sin, vecs[k].ack);
      chk_all($sformatf("vec%0d", k), vecs[k].exp_out, vecs[k].exp_valid,
              vecs[k].exp_ovr, vecs[k].exp_busy, vecs[k].exp_cnt);
    end

    // T2: partial 0xFF frame abandoned by carga, then clean 0xCC.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    shift_bits(8'hFF, 3, 1'b0);
    chk_all("t2_partial", 8'h00, 1'b0, 1'b0, 1'b1, 3'd3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("t2_reload", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    shift_bits(8'hCC, 8, 1'b0);
    chk_all("t2_done", 8'hCC, 1'b1, 1'b0, 1'b0, 3'd0);

    // T4: ack coincides with completion of the next frame.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    shift_bits(8'hAA, 8, 1'b0);
    chk_all("t4_first", 8'hAA, 1'b1, 1'b0, 1'b0, 3'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    shift_bits(8'h55, 8, 1'b1);
    chk_all("t4_second", 8'h55, 1'b1, 1'b0, 1'b0, 3'd0);

    // T5: carga and shift together -> no bit sampled.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    shift_bits(8'hFF, 2, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk_all("t5_collide", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    shift_bits(8'h96, 8, 1'b0);
    chk_all("t5_done", 8'h96, 1'b1, 1'b0, 1'b0, 3'd0);

    // T6: reset mid-frame with a byte pending wipes everything.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    shift_bits(8'hA5, 4, 1'b0);
    chk_all("t6_partial", 8'h96, 1'b1, 1'b0, 1'b1, 3'd4);
    do_reset();
    chk_all("t6_reset", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    shift_bits(8'h3C, 8, 1'b0);
    chk_all("t6_done", 8'h3C, 1'b1, 1'b0, 1'b0, 3'd0);

    // Back-to-back frames with no gap cycle and no carga between them.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk_all("b2b_ack", 8'h3C, 1'b0, 1'b0, 1'b0, 3'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    shift_bits(8'h81, 8, 1'b0);
    chk_all("b2b_first", 8'h81, 1'b1, 1'b0, 1'b0, 3'd0);
    shift_bits(8'h7E, 8, 1'b1);
    chk_all("b2b_second", 8'h7E, 1'b1, 1'b0, 1'b0, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
